box_motion_ctrl: RTL

//  Per-frame position/colour engine for the on-screen box. Runs on the pixel clock beside the XY counter.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/frame_tick.sv | 11 +
 rtl/box_motion_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared screen defaults, colour palette, direction decode and box-motion FSM types
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  localparam rgb_t PALETTE [8] = '{
    rgb_t'(12'hFFF), rgb_t'(12'hF00), rgb_t'(12'h0F0), rgb_t'(12'h00F),
    rgb_t'(12'hFF0), rgb_t'(12'h0FF), rgb_t'(12'hF0F), rgb_t'(12'hF80)
  };
  typedef enum logic [1:0] {HOLD, POS, NEG} dir_t;
  typedef enum logic [2:0] {IDLE, LATCH, CALC_X, CALC_Y, COMMIT} bm_state_t;
  typedef struct packed {
    logic [9:0] pos;
    logic       hit;
  } step_t;
  function automatic dir_t decode_dir(input logic [1:0] d);
    return d == 2'b01 ? POS : d == 2'b10 ? NEG : HOLD;
  endfunction
  // One axis move with clamping; only an overshoot past either limit counts as a wall hit.
  function automatic step_t advance(input logic [9:0] pos, input dir_t d,
                                    input logic [9:0] step, input logic [9:0] lim);
    logic signed [10:0] n;
    step_t s;
    n = d == POS ? $signed({1'b0, pos}) + $signed({1'b0, step}) :
        d == NEG ? $signed({1'b0, pos}) - $signed({1'b0, step}) : $signed({1'b0, pos});
    s.hit = (n < 11'sd0) || (n > $signed({1'b0, lim}));
    s.pos = n < 11'sd0 ? 10'd0 : s.hit ? lim : n[9:0];
    return s;
  endfunction
endpackage

// File: rtl/frame_tick.sv
// frame_tick: one-clk pulse on the falling edge of active-low vs; reset parks the history at the asserted level
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic tick
);
  logic vs_q;
  always_ff @(posedge clk) vs_q <= rst ? 1'b0 : vs;
  assign tick = vs_q & ~vs;
endmodule

// File: rtl/box_motion_ctrl.sv
// box_motion_ctrl: per-frame box position update with edge clamping and palette advance on wall hits
module box_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 4,
  parameter int START_X  = 304,
  parameter int START_Y  = 224
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs,
  input  logic [1:0] dir_x,
  input  logic [1:0] dir_y,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [9:0] box_size,
  output logic [3:0] box_r,
  output logic [3:0] box_g,
  output logic [3:0] box_b
);
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0] STEP_W = 10'(STEP);
  bm_state_t state, state_n;
  dir_t dx_q, dy_q;
  step_t sx_q, sy_q;
  logic tick, latch_en, calc_x_en, calc_y_en, commit_en;
  logic [2:0] idx, idx_n;
  frame_tick u_tick (.clk(clk), .rst(rst), .vs(vs), .tick(tick));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // Ticks outside IDLE are simply not looked at, which drops them.
  always_comb begin
    state_n = state == IDLE   ? (tick ? LATCH : IDLE) :
              state == LATCH  ? CALC_X :
              state == CALC_X ? CALC_Y :
              state == CALC_Y ? COMMIT : IDLE;
  end
  always_comb begin
    latch_en  = state == LATCH;
    calc_x_en = state == CALC_X;
    calc_y_en = state == CALC_Y;
    commit_en = state == COMMIT;
  end
  assign box_size = 10'(BOX_SIZE);
  assign idx_n    = idx + {2'b00, sx_q.hit | sy_q.hit};
  // Both axes and the colour load on the same edge so the drawer never sees a half-update.
  always_ff @(posedge clk) begin
    if (rst) begin
      box_x <= 10'(START_X);
      box_y <= 10'(START_Y);
      idx <= '0;
      {box_r, box_g, box_b} <= PALETTE[0];
      dx_q <= HOLD;
      dy_q <= HOLD;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      if (latch_en) begin
        dx_q <= decode_dir(dir_x);
        dy_q <= decode_dir(dir_y);
      end
      if (calc_x_en) sx_q <= advance(box_x, dx_q, STEP_W, X_MAX);
      if (calc_y_en) sy_q <= advance(box_y, dy_q, STEP_W, Y_MAX);
      if (commit_en) begin
        box_x <= sx_q.pos;
        box_y <= sy_q.pos;
        idx <= idx_n;
        {box_r, box_g, box_b} <= PALETTE[idx_n];
      end
    end
  end
endmodule
